// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Drains the async-FIFO read port and packs `burst` words into one
//            beat on a valid/ready interface. With BURST_TIMEOUT_EN defined,
//            a partial burst is flushed after `timeout` empty cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int data    = 6,
    parameter int burst   = 4,
    parameter int timeout = 16
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic                         r_empty,
    input  logic [data-1:0]              rdata,
    output logic                         r_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [burst*data-1:0]        m_data,
    output logic [$clog2(burst+1)-1:0]   m_len,
    output logic [15:0]                  beat_cnt
);

    localparam int LW = $clog2(burst + 1);
    localparam int TW = $clog2(timeout + 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LW-1:0]           r_idx;
    logic [burst*data-1:0]   r_buf;
    logic [LW-1:0]           r_len;
    logic [15:0]             r_beat_cnt;
    logic                    w_pop;
    logic                    w_last;
    logic                    w_hs;
    logic                    w_tmo;
`ifdef BURST_TIMEOUT_EN
    logic [TW-1:0]           r_idle;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_last      = 1'b0;
        w_hs        = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_FILL: begin
                // rrst gating keeps the pop strobe low throughout reset
                w_pop  = rrst && !r_empty;
                w_last = w_pop && (r_idx == LW'(burst - 1));
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
`ifdef BURST_TIMEOUT_EN
                else if (!w_pop && (r_idx != '0) && (r_idle == TW'(timeout))) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (m_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_state    <= S_FILL;
            r_idx      <= '0;
            r_buf      <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_buf[int'(r_idx)*data +: data] <= rdata;
                r_idx                           <= r_idx + LW'(1);
            end
            if (w_last) begin
                r_len <= LW'(burst);
            end
            if (w_tmo) begin
                r_len <= r_idx;
            end
            if (w_hs) begin
                r_idx      <= '0;
                r_buf      <= '0;
                r_len      <= '0;
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
        end
    end

`ifdef BURST_TIMEOUT_EN
    // Counts only while a partial burst is waiting on an empty FIFO
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            r_idle <= '0;
        end else if ((r_state == S_FILL) && (r_idx != '0) && !w_pop && !w_tmo) begin
            r_idle <= r_idle + TW'(1);
        end else begin
            r_idle <= '0;
        end
    end
`endif

    assign r_en     = w_pop;
    assign m_valid  = (r_state == S_HOLD);
    assign m_data   = r_buf;
    assign m_len    = r_len;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Scoreboard bench: FIFO model drives the read port, expected
//            beats are queued by stimulus and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DATA  = 6;
    localparam int BURST = 4;
    localparam int LW    = 3;

    typedef struct {
        logic [BURST*DATA-1:0] d;
        logic [LW-1:0]         len;
    } beat_t;

    logic                  rclk = 1'b0;
    logic                  rrst;
    logic                  r_empty;
    logic [DATA-1:0]       rdata;
    logic                  r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [BURST*DATA-1:0] m_data;
    logic [LW-1:0]         m_len;
    logic [15:0]           beat_cnt;

    logic [DATA-1:0] fifo_q[$];
    beat_t           exp_q[$];
    int              checks   = 0;
    int              failures = 0;
    int              pops     = 0;
    logic [15:0]     exp_cnt  = 16'd0;
    logic            stall    = 1'b0;
    logic            tgl      = 1'b0;

    fifo_burst_reader #(.data(DATA), .burst(BURST), .timeout(16)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .r_empty  (r_empty),
        .rdata    (rdata),
        .r_en     (r_en),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_len    (m_len),
        .beat_cnt (beat_cnt)
    );

    always #5 rclk = ~rclk;

    function automatic logic [BURST*DATA-1:0] pack4(input logic [DATA-1:0] a, b, c, e);
        return {e, c, b, a};
    endfunction

    task automatic expect_beat(input logic [BURST*DATA-1:0] d, input logic [LW-1:0] len);
        beat_t b;
        b.d   = d;
        b.len = len;
        exp_q.push_back(b);
    endtask

    task automatic push4(input logic [DATA-1:0] a, b, c, e);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        fifo_q.push_back(c);
        fifo_q.push_back(e);
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < max) begin
            @(negedge rclk);
            n++;
        end
        checks++;
        if (n >= max) begin
            failures++;
            $display("FAIL %s drain timeout got_pending=%0d exp_pending=0", name, exp_q.size());
        end
        repeat (3) @(negedge rclk);
    endtask

    // FIFO model: present head word, consume it when the DUT pops
    always @(negedge rclk) begin
        tgl     = ~tgl;
        r_empty = (fifo_q.size() == 0) || (stall && tgl);
        rdata   = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        if (r_en) begin
            checks++;
            if (r_empty) begin
                failures++;
                $display("FAIL pop_while_empty got r_en=1 exp r_en=0");
            end
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
        end
    end

    // Monitor / scoreboard
    always @(negedge rclk) begin
        #2;
        checks++;
        if (!rrst) begin
            exp_cnt = 16'd0;
            if (m_valid !== 1'b0 || m_data !== '0 || m_len !== '0 || beat_cnt !== 16'd0 || r_en !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got v=%b d=%h l=%0d cnt=%0d ren=%b exp all 0",
                         m_valid, m_data, m_len, beat_cnt, r_en);
            end
        end else begin
            if (beat_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL beat_cnt got=%0d exp=%0d", beat_cnt, exp_cnt);
            end
            if (m_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got d=%h l=%0d exp none", m_data, m_len);
                end else begin
                    if (m_data !== exp_q[0].d || m_len !== exp_q[0].len || r_en !== 1'b0) begin
                        failures++;
                        $display("FAIL beat got d=%h l=%0d ren=%b exp d=%h l=%0d ren=0",
                                 m_data, m_len, r_en, exp_q[0].d, exp_q[0].len);
                    end
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt = exp_cnt + 16'd1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;
        rrst    = 1'b0;
        m_ready = 1'b1;
        // Reset held with data waiting in the FIFO
        push4(6'h01, 6'h02, 6'h03, 6'h04);
        expect_beat(24'h103081, 3'd4);  // 0x01,0x02,0x03,0x04 LSB-first
        repeat (4) @(negedge rclk);
        rrst = 1'b1;
        wait_idle(50, "full_burst");
        checks++;
        if (pops != 4 || beat_cnt !== 16'd1) begin
            failures++;
            $display("FAIL full_burst_pops got pops=%0d cnt=%0d exp pops=4 cnt=1", pops, beat_cnt);
        end

        // Backpressure
        m_ready = 1'b0;
        push4(6'h05, 6'h06, 6'h07, 6'h08);
        push4(6'h09, 6'h0A, 6'h0B, 6'h0C);
        expect_beat(pack4(6'h05, 6'h06, 6'h07, 6'h08), 3'd4);
        expect_beat(pack4(6'h09, 6'h0A, 6'h0B, 6'h0C), 3'd4);
        n = 0;
        do begin
            @(negedge rclk);
            #3;
            n++;
        end while (!m_valid && n < 50);
        p = pops;
        repeat (10) @(negedge rclk);
        checks++;
        if (pops != p || !m_valid) begin
            failures++;
            $display("FAIL backpressure got pops=%0d v=%b exp pops=%0d v=1", pops, m_valid, p);
        end
        m_ready = 1'b1;
        wait_idle(50, "backpressure");

        // Empty flag toggling every cycle
        stall = 1'b1;
        push4(6'h11, 6'h12, 6'h13, 6'h14);
        expect_beat(pack4(6'h11, 6'h12, 6'h13, 6'h14), 3'd4);
        wait_idle(50, "empty_stall");
        stall = 1'b0;

        // Partial burst
        fifo_q.push_back(6'h31);
        fifo_q.push_back(6'h32);
`ifdef BURST_TIMEOUT_EN
        expect_beat(pack4(6'h31, 6'h32, 6'h00, 6'h00), 3'd2);
        wait_idle(100, "timeout_flush");
`else
        repeat (100) @(negedge rclk);
        #3;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout got v=%b exp v=0", m_valid);
        end
        fifo_q.push_back(6'h33);
        fifo_q.push_back(6'h34);
        expect_beat(pack4(6'h31, 6'h32, 6'h33, 6'h34), 3'd4);
        wait_idle(50, "partial_complete");
`endif

        // Reset after three pops discards them
        fifo_q.push_back(6'h21);
        fifo_q.push_back(6'h22);
        fifo_q.push_back(6'h23);
        n = 0;
        while (fifo_q.size() != 0 && n < 20) begin
            @(negedge rclk);
            n++;
        end
        repeat (2) @(negedge rclk);
        rrst = 1'b0;
        repeat (2) @(negedge rclk);
        rrst = 1'b1;
        push4(6'h3A, 6'h3B, 6'h3C, 6'h3D);
        expect_beat(pack4(6'h3A, 6'h3B, 6'h3C, 6'h3D), 3'd4);
        wait_idle(50, "mid_reset");
        checks++;
        if (beat_cnt !== 16'd1) begin
            failures++;
            $display("FAIL mid_reset_cnt got=%0d exp=1", beat_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
